fcmp_pipe: RTL and testbench
============================

FCMP_PIPE -- requirements
Module: fcmp_pipe

Interface
REQ-001 SHALL have parameter TAG_W, default 5, width of the pass-through destination tag.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; one clock, reset is asynchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  request accepted when in_valid && in_ready at a clk edge.
REQ-006 SHALL have port op  input  2  00 FEQ, 01 FLT, 10 FLE, 11 FGE.
REQ-007 SHALL have port x1  input  32  IEEE-754 single, left operand.
REQ-008 SHALL have port x2  input  32  IEEE-754 single, right operand.
REQ-009 SHALL have port in_tag  input  TAG_W  destination tag.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  result consumed when out_valid && out_ready at a clk edge.
REQ-012 SHALL have port y  output  1  comparison result, x1 op x2.
REQ-013 SHALL have port out_tag  output  TAG_W  tag of the request that produced y.

Function
REQ-014 SHALL implement two registered stages: S1 (operand capture + key form), S2 (compare + result).
REQ-015 SHALL map each operand to a 32-bit ordered key: exponent==0 -> 32'h8000_0000 (denormals and +/-0 flushed to one zero); else sign 0 -> {1'b1, x[30:0]}; sign 1 -> ~x.
REQ-016 SHALL compute in S2 with unsigned key compare: FEQ k1==k2, FLT k1<k2, FLE k1<=k2, FGE k1>=k2.
REQ-017 SHALL NOT special-case NaN or infinity; such encodings compare by key.
REQ-018 SHALL give latency exactly 2 cycles from accept to out_valid when out_ready is held high.
REQ-019 SHALL sustain one accept per cycle when out_ready is high.
REQ-020 SHALL hold y, out_tag and out_valid stable while out_valid && !out_ready.
REQ-021 SHALL advance S1 into S2 when S2 empty or S2 consumed this cycle; S1 accepts when S1 empty or S1 advancing.
REQ-022 SHALL drive in_ready = !s1_valid || s1_advance, combinationally from out_ready; no combinational path from in_valid to in_ready.
REQ-023 SHALL hold both stages full with in_ready low after two accepts with out_ready low; no request lost or duplicated.
REQ-024 SHALL, on simultaneous consume at S2 and accept at S1 while full, shift both stages in the same edge.
REQ-025 SHALL ignore op, x1, x2, in_tag when in_valid is low.

Reset
REQ-026 SHALL clear s1_valid and s2_valid (out_valid=0, in_ready=1) immediately on rst assertion.
REQ-027 SHALL reset y=0 and out_tag=0; data registers other than outputs need no reset.
REQ-028 SHALL discard any in-flight request when rst asserts mid-operation; none reappears after release.
REQ-029 SHALL accept a request on the first clk edge after rst deasserts.

Structure
REQ-030 SHALL take the op encoding (cmp_op_t enum, FEQ/FLT/FLE/FGE) from the shared FPU package fpu_pkg.
REQ-031 SHALL place the key mapping of REQ-015 in one sub-module fcmp_key, instantiated twice in S1.
REQ-032 SHALL keep the handshake control in this module; no FIFO instance.

Verification
REQ-033 SHALL cover FGE x1=3F80_0000 (1.0), x2=4000_0000 (2.0), tag 3 -> y=0, out_tag=3, out_valid 2 cycles after accept.
REQ-034 SHALL cover FEQ x1=8000_0000, x2=0000_0000 -> y=1; FLT x1=BF80_0000, x2=3F80_0000 -> y=1; FLE x1=C000_0000, x2=BF80_0000 -> y=1.
REQ-035 SHALL cover back-to-back 4 requests, out_ready=1 -> 4 results on consecutive cycles, tags in order.
REQ-036 SHALL cover out_ready=0 for 5 cycles after 3 offered requests -> in_ready low after 2 accepts, outputs stable, then all 3 results in order once out_ready=1.
REQ-037 SHALL cover rst pulse between clock edges with both stages full -> out_valid=0 and in_ready=1 before next edge, no stale result afterwards.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: comparison opcode encoding and single-precision constants.
package fpu_pkg;

  localparam int DATA_W = 32;

  // Key value shared by +0, -0 and every denormal
  localparam logic [DATA_W-1:0] KEY_ZERO = 32'h8000_0000;

  typedef enum logic [1:0] {
    FEQ = 2'b00,
    FLT = 2'b01,
    FLE = 2'b10,
    FGE = 2'b11
  } cmp_op_t;

endpackage

// File: rtl/fcmp_key.sv
// Maps an IEEE-754 single to a 32-bit key whose unsigned order equals float order.
module fcmp_key
  import fpu_pkg::*;
(
  input  logic [DATA_W-1:0] i_x,
  output logic [DATA_W-1:0] o_key
);

  logic w_zero_exp;

  assign w_zero_exp = (i_x[30:23] == 8'd0);

  // Positives sit above KEY_ZERO; negatives invert so larger magnitude sorts lower
  assign o_key = w_zero_exp ? KEY_ZERO :
                 (i_x[31] ? ~i_x : {1'b1, i_x[30:0]});

endmodule

// File: rtl/fcmp_pipe.sv
// Two-stage floating-point compare (FEQ/FLT/FLE/FGE) with valid/ready flow control.
module fcmp_pipe
  import fpu_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          op,
  input  logic [DATA_W-1:0]   x1,
  input  logic [DATA_W-1:0]   x2,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                y,
  output logic [TAG_W-1:0]    out_tag
);

  function automatic logic f_cmp(input cmp_op_t i_op,
                                 input logic [DATA_W-1:0] i_k1,
                                 input logic [DATA_W-1:0] i_k2);
    logic r;
    r = 1'b0;
    case (i_op)
      FEQ:     r = (i_k1 == i_k2);
      FLT:     r = (i_k1 <  i_k2);
      FLE:     r = (i_k1 <= i_k2);
      FGE:     r = (i_k1 >= i_k2);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  logic                r_vld_p1;
  logic                r_vld_p2;
  cmp_op_t             r_op_p1;
  logic [DATA_W-1:0]   r_x1_p1;
  logic [DATA_W-1:0]   r_x2_p1;
  logic [TAG_W-1:0]    r_tag_p1;
  logic                r_y_p2;
  logic [TAG_W-1:0]    r_tag_p2;

  logic                w_s2_free;
  logic                w_s1_adv;
  logic                w_accept;
  logic [DATA_W-1:0]   w_key1;
  logic [DATA_W-1:0]   w_key2;

  // S2 can take new data when empty or being drained this cycle
  assign w_s2_free = !r_vld_p2 || out_ready;
  assign w_s1_adv  = r_vld_p1 && w_s2_free;
  assign in_ready  = !r_vld_p1 || w_s1_adv;
  assign w_accept  = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else begin
      if (w_accept)
        r_vld_p1 <= 1'b1;
      else if (w_s1_adv)
        r_vld_p1 <= 1'b0;

      if (w_s1_adv)
        r_vld_p2 <= 1'b1;
      else if (out_ready)
        r_vld_p2 <= 1'b0;
    end
  end

  // ---- S1: operand capture ----
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_op_p1  <= cmp_op_t'(op);
      r_x1_p1  <= x1;
      r_x2_p1  <= x2;
      r_tag_p1 <= in_tag;
    end
  end

  fcmp_key u_key1 (.i_x(r_x1_p1), .o_key(w_key1));
  fcmp_key u_key2 (.i_x(r_x2_p1), .o_key(w_key2));

  // ---- S2: compare and result ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y_p2   <= 1'b0;
      r_tag_p2 <= '0;
    end else if (w_s1_adv) begin
      r_y_p2   <= f_cmp(r_op_p1, w_key1, w_key2);
      r_tag_p2 <= r_tag_p1;
    end
  end

  assign out_valid = r_vld_p2;
  assign y         = r_y_p2;
  assign out_tag   = r_tag_p2;

endmodule

// File: tb/tb_fcmp_pipe.sv
// Self-checking bench for fcmp_pipe: directed vectors, flow control, reset, randomized traffic.
module tb_fcmp_pipe;
  import fpu_pkg::*;

  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    op;
  logic [31:0]   x1, x2;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic          y;
  logic [TW-1:0] out_tag;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic          ey;
    logic [TW-1:0] etag;
  } exp_t;

  fcmp_pipe #(.TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .x1(x1), .x2(x2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  // Float order as signed magnitude; zero and denormals collapse to 0
  function automatic longint fval(input logic [31:0] a);
    longint m;
    m = a[30:0];
    if (a[30:23] == 8'd0) return 0;
    return a[31] ? -m : m;
  endfunction

  function automatic logic ref_y(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint va, vb;
    va = fval(a);
    vb = fval(b);
    case (o)
      2'b00:   return va == vb;
      2'b01:   return va <  vb;
      2'b10:   return va <= vb;
      default: return va >= vb;
    endcase
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return {r[31], 8'h00, r[22:0]};
      3: return {r[31], 31'h7F80_0000};
      4: return {r[31], 8'hFF, r[22:0] | 23'h1};
      default: return r;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; op = 2'b00; x1 = '0; x2 = '0; in_tag = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (y !== 1'b0) begin failures++; $display("FAIL reset_y got=%b exp=0", y); end
    checks++; if (out_tag !== '0) begin failures++; $display("FAIL reset_out_tag got=%0d exp=0", out_tag); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [1:0]    t_op [4] = '{2'b11, 2'b00, 2'b01, 2'b10};
    logic [31:0]   t_x1 [4] = '{32'h3F80_0000, 32'h8000_0000, 32'hBF80_0000, 32'hC000_0000};
    logic [31:0]   t_x2 [4] = '{32'h4000_0000, 32'h0000_0000, 32'h3F80_0000, 32'hBF80_0000};
    logic [TW-1:0] t_tag[4] = '{5'd3, 5'd4, 5'd5, 5'd6};
    logic          t_y  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      out_ready = 1'b1;
      in_valid = 1'b1; op = t_op[i]; x1 = t_x1[i]; x2 = t_x2[i]; in_tag = t_tag[i];
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL dir%0d_in_ready got=%b exp=1", i, in_ready); end
      step();
      in_valid = 1'b0; x1 = $urandom; x2 = $urandom; in_tag = '1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL dir%0d_early_valid got=%b exp=0", i, out_valid); end
      step();
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL dir%0d_latency got=%b exp=1", i, out_valid); end
      checks++; if (y !== t_y[i]) begin failures++; $display("FAIL dir%0d_y got=%b exp=%b", i, y, t_y[i]); end
      checks++; if (out_tag !== t_tag[i]) begin failures++; $display("FAIL dir%0d_tag got=%0d exp=%0d", i, out_tag, t_tag[i]); end
      step();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL dir%0d_drain got=%b exp=0", i, out_valid); end
    end
  endtask

  task automatic test_back_to_back();
    logic [TW-1:0] tg[4];
    logic          ey[4];
    logic [1:0]    ops[4];
    logic [31:0]   a[4], b[4];
    for (int i = 0; i < 4; i++) begin
      ops[i] = 2'($urandom_range(0, 3)); a[i] = rand_fp(); b[i] = (i == 1) ? a[i] : rand_fp();
      tg[i] = TW'(8 + i); ey[i] = ref_y(ops[i], a[i], b[i]);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      in_valid = (c < 4);
      if (c < 4) begin op = ops[c]; x1 = a[c]; x2 = b[c]; in_tag = tg[c]; end
      #1;
      if (c < 4) begin
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready c=%0d got=%b exp=1", c, in_ready); end
      end
      checks++;
      if (out_valid !== (c >= 2 && c < 6)) begin
        failures++; $display("FAIL b2b_out_valid c=%0d got=%b exp=%b", c, out_valid, (c >= 2 && c < 6));
      end
      if (c >= 2 && c < 6) begin
        checks++; if (out_tag !== tg[c-2]) begin failures++; $display("FAIL b2b_tag c=%0d got=%0d exp=%0d", c, out_tag, tg[c-2]); end
        checks++; if (y !== ey[c-2]) begin failures++; $display("FAIL b2b_y c=%0d got=%b exp=%b", c, y, ey[c-2]); end
      end
      step();
    end
  endtask

  task automatic test_stall();
    logic [TW-1:0] tg[3];
    logic          ey[3];
    logic [1:0]    ops[3];
    logic [31:0]   a[3], b[3];
    int k = 0, n = 0;
    for (int i = 0; i < 3; i++) begin
      ops[i] = 2'($urandom_range(0, 3)); a[i] = rand_fp(); b[i] = rand_fp();
      tg[i] = TW'(13 + i); ey[i] = ref_y(ops[i], a[i], b[i]);
    end
    for (int c = 0; c < 12; c++) begin
      out_ready = (c >= 5);
      in_valid = (k < 3);
      if (k < 3) begin op = ops[k]; x1 = a[k]; x2 = b[k]; in_tag = tg[k]; end
      else begin x1 = $urandom; x2 = $urandom; end
      #1;
      if (c < 2 || c == 5) begin
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_in_ready_hi c=%0d got=%b exp=1", c, in_ready); end
      end
      if (c >= 2 && c <= 4) begin
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready_lo c=%0d got=%b exp=0", c, in_ready); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_hold_valid c=%0d got=%b exp=1", c, out_valid); end
        checks++; if (out_tag !== tg[0] || y !== ey[0]) begin
          failures++; $display("FAIL stall_hold_data c=%0d got=%0d/%b exp=%0d/%b", c, out_tag, y, tg[0], ey[0]);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (n >= 3) begin failures++; $display("FAIL stall_extra_result tag=%0d", out_tag); end
        else if (out_tag !== tg[n] || y !== ey[n]) begin
          failures++; $display("FAIL stall_result%0d got=%0d/%b exp=%0d/%b", n, out_tag, y, tg[n], ey[n]);
        end
        n++;
      end
      if (in_valid && in_ready) k++;
      step();
    end
    in_valid = 1'b0;
    checks++; if (n !== 3) begin failures++; $display("FAIL stall_count got=%0d exp=3", n); end
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    logic [TW-1:0] tag_ctr = '0;
    logic prev_stall = 1'b0, prev_y = 1'b0;
    logic [TW-1:0] prev_tag = '0;
    int drain = 0;
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      op = 2'($urandom_range(0, 3));
      x1 = rand_fp();
      case ($urandom_range(0, 9))
        0, 1, 2: x2 = x1;
        3:       x2 = x1 ^ 32'h8000_0000;
        default: x2 = rand_fp();
      endcase
      in_tag = tag_ctr;
      #1;
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || y !== prev_y || out_tag !== prev_tag) begin
          failures++; $display("FAIL rnd_stall_stable c=%0d got=%b/%b/%0d exp=1/%b/%0d", c, out_valid, y, out_tag, prev_y, prev_tag);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin failures++; $display("FAIL rnd_unexpected c=%0d tag=%0d", c, out_tag); end
        else begin
          e = q.pop_front();
          if (y !== e.ey || out_tag !== e.etag) begin
            failures++; $display("FAIL rnd_result c=%0d got=%b/%0d exp=%b/%0d", c, y, out_tag, e.ey, e.etag);
          end
        end
      end
      if (in_valid && in_ready) begin
        e.ey = ref_y(op, x1, x2); e.etag = tag_ctr;
        q.push_back(e);
        tag_ctr++;
      end
      prev_stall = out_valid && !out_ready; prev_y = y; prev_tag = out_tag;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    while (q.size() != 0 && drain < 10) begin
      #1;
      if (out_valid) begin
        checks++;
        e = q.pop_front();
        if (y !== e.ey || out_tag !== e.etag) begin
          failures++; $display("FAIL rnd_drain got=%b/%0d exp=%b/%0d", y, out_tag, e.ey, e.etag);
        end
      end
      drain++;
      step();
    end
    checks++; if (q.size() != 0) begin failures++; $display("FAIL rnd_lost got=%0d pending exp=0", q.size()); end
  endtask

  task automatic test_reset_midflight();
    logic ec;
    out_ready = 1'b0;
    in_valid = 1'b1; op = 2'b01; x1 = 32'h3F80_0000; x2 = 32'h4000_0000; in_tag = 5'd20;
    step();
    in_tag = 5'd21;
    step();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      failures++; $display("FAIL rstmid_full got=%b/%b exp=0/1", in_ready, out_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
    #2 rst = 1'b0;
    in_valid = 1'b1; op = 2'b10; x1 = 32'hC000_0000; x2 = 32'h4000_0000; in_tag = 5'd22; out_ready = 1'b1;
    ec = ref_y(op, x1, x2);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_stale got=%b exp=0", out_valid); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_no_ghost got=%b exp=0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1 || out_tag !== 5'd22 || y !== ec) begin
      failures++; $display("FAIL rstmid_first_accept got=%b/%0d/%b exp=1/22/%b", out_valid, out_tag, y, ec);
    end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_after got=%b exp=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_random();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
